prim_clock_gate_ctrl: RTL and testbench

Idle-driven enable controller for `prim_clock_gating`; it produces the `en_i` that the gating cell latches. It watches core activity and a sleep request, applies an idle hysteresis before gating, and handles the wake-up handshake with a release delay. It also keeps a saturating count of gated cycles. It runs on the free-running (ungated) clock and sits beside the core clock gate in the core wrapper.

---
 rtl/prim_clock_gate_pkg.sv | 18 +
 rtl/prim_sat_counter.sv | 38 +++
 rtl/prim_clock_gate_ctrl.sv | 134 +++++++++++++
 tb/tb_prim_clock_gate_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_clock_gate_pkg.sv
// Shared types and defaults for the idle-driven clock-gate enable controller.
package prim_clock_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        GATED = 2'b10,
        WAKE  = 2'b11
    } ctrl_state_e;

    localparam int unsigned DefaultIdleCycles = 32'd4;
    localparam int unsigned DefaultWakeCycles = 32'd2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/prim_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module prim_sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Next count: clear first, then increment unless already all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/prim_clock_gate_ctrl.sv
// Enable controller for prim_clock_gating: idle hysteresis before gating, timed
// release on wake, and a saturating count of gated cycles. Runs on the free clock.
module prim_clock_gate_ctrl
    import prim_clock_gate_pkg::*;
#(
    parameter int unsigned IdleCycles = DefaultIdleCycles,
    parameter int unsigned WakeCycles = DefaultWakeCycles,
    parameter int unsigned StatWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sleep_req_i,
    input  logic                 core_busy_i,
    input  logic                 wake_req_i,
    input  logic                 clear_stats_i,
    output logic                 clock_en_o,
    output logic                 sleep_ack_o,
    output logic                 wake_ack_o,
    output logic                 core_sleeping_o,
    output logic [StatWidth-1:0] gated_cycles_o
);

    localparam int unsigned CntMax = max_u(IdleCycles, WakeCycles);
    localparam int unsigned CntW   = $clog2(CntMax + 32'd1);
    localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 32'd1);
    localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 32'd1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1'b1);

    if (IdleCycles < 32'd1) begin : g_idle_chk
        $error("prim_clock_gate_ctrl: IdleCycles must be at least 1");
    end
    if (WakeCycles < 32'd1) begin : g_wake_chk
        $error("prim_clock_gate_ctrl: WakeCycles must be at least 1");
    end

    ctrl_state_e     state_q;
    ctrl_state_e     state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            wake_ack_d;
    logic            clock_en_q;
    logic            sleep_ack_q;
    logic            wake_ack_q;
    logic            core_sleeping_q;
    logic            adv_s;
    logic            stat_inc_s;

    // A wake request vetoes sleep entry, so it also aborts a drain in progress.
    assign adv_s = sleep_req_i & ~core_busy_i & ~wake_req_i;

    // Next-state and hysteresis/release counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wake_ack_d = 1'b0;
        case (state_q)
            RUN: begin
                if (adv_s) begin
                    state_d = DRAIN;
                    cnt_d   = IdleLoad;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!adv_s) begin
                    state_d = RUN;
                end else if (cnt_q == '0) begin
                    state_d = GATED;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            GATED: begin
                if (wake_req_i) begin
                    state_d = WAKE;
                    cnt_d   = WakeLoad;
                end else begin
                    state_d = GATED;
                end
            end
            WAKE: begin
                if (cnt_q == '0) begin
                    state_d    = RUN;
                    wake_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and Moore outputs, registered from the next state so the enable
    // only ever changes on the rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= RUN;
            cnt_q           <= '0;
            clock_en_q      <= 1'b1;
            sleep_ack_q     <= 1'b0;
            wake_ack_q      <= 1'b0;
            core_sleeping_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            clock_en_q      <= (state_d != GATED);
            sleep_ack_q     <= (state_d == GATED);
            wake_ack_q      <= wake_ack_d;
            core_sleeping_q <= (state_d == GATED) || (state_d == WAKE);
        end
    end

    assign stat_inc_s = (state_q == GATED);

    prim_sat_counter #(
        .Width (StatWidth)
    ) u_gated_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (stat_inc_s),
        .clr_i (clear_stats_i),
        .q_o   (gated_cycles_o)
    );

    assign clock_en_o      = clock_en_q;
    assign sleep_ack_o     = sleep_ack_q;
    assign wake_ack_o      = wake_ack_q;
    assign core_sleeping_o = core_sleeping_q;

endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// Scoreboard bench for prim_clock_gate_ctrl: default instance plus a 3-bit-stat
// instance sharing the same stimulus.
module tb_prim_clock_gate_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic sleep_req;
    logic core_busy;
    logic wake_req;
    logic clear_stats;

    logic        ce, sa, wa, cs;
    logic [31:0] gc;
    logic        ce3, sa3, wa3, cs3;
    logic [2:0]  gc3;

    always #5 clk = ~clk;

    prim_clock_gate_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .sleep_req_i     (sleep_req),
        .core_busy_i     (core_busy),
        .wake_req_i      (wake_req),
        .clear_stats_i   (clear_stats),
        .clock_en_o      (ce),
        .sleep_ack_o     (sa),
        .wake_ack_o      (wa),
        .core_sleeping_o (cs),
        .gated_cycles_o  (gc)
    );

    prim_clock_gate_ctrl #(.StatWidth(3)) dut_sat (
        .clk_i           (clk),
        .rst_i           (rst),
        .sleep_req_i     (sleep_req),
        .core_busy_i     (core_busy),
        .wake_req_i      (wake_req),
        .clear_stats_i   (clear_stats),
        .clock_en_o      (ce3),
        .sleep_ack_o     (sa3),
        .wake_ack_o      (wa3),
        .core_sleeping_o (cs3),
        .gated_cycles_o  (gc3)
    );

    typedef struct packed {
        logic        ce;
        logic        sa;
        logic        wa;
        logic        cs;
        logic [31:0] gc;
        logic [2:0]  gc3;
    } obs_t;

    obs_t        sb[$];
    obs_t        e;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] g32;
    logic [2:0]  g3;

    function automatic obs_t observe();
        return {ce, sa, wa, cs, gc, gc3};
    endfunction

    // Expected stat counters: clear wins, otherwise count edges taken in GATED.
    function automatic void account(input bit was_gated, input bit clr);
        if (clr) begin
            g32 = 32'd0;
            g3  = 3'd0;
        end else if (was_gated) begin
            if (g32 != 32'hFFFF_FFFF) g32 = g32 + 32'd1;
            if (g3 != 3'd7) g3 = g3 + 3'd1;
        end
    endfunction

    task automatic push(input bit xce, input bit xsa, input bit xwa, input bit xcs);
        sb.push_back({xce, xsa, xwa, xcs, g32, g3});
    endtask

    task automatic step(input bit s, input bit b, input bit w, input bit c);
        sleep_req   = s;
        core_busy   = b;
        wake_req    = w;
        clear_stats = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sleep_req = 1'b0; core_busy = 1'b0; wake_req = 1'b0; clear_stats = 1'b0;
        g32 = 32'd0; g3 = 3'd0;
        #3;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); n_vec++;
        if (observe() !== e) begin
            n_err++; $display("FAIL reset_async got=%h want=%h", observe(), e);
        end
        for (int k = 0; k < 2; k++) begin
            push(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL reset_held k=%0d got=%h want=%h", k, observe(), e);
            end
        end
        rst = 1'b0;
    endtask

    // From RUN with sleep held: DRAIN for edges 0..3, GATED after edge 4.
    task automatic test_gate(input int n);
        for (int k = 0; k < n; k++) begin
            account(k >= 5, 1'b0);
            push(k < 4, k >= 4, 1'b0, k >= 4);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL gate edge=%0d got=%h want=%h", k, observe(), e);
            end
        end
    endtask

    // From GATED: wake at edge w, ack after w+2; with hold, re-gate after w+7.
    task automatic test_wake(input bit hold);
        int n;
        n = hold ? 8 : 6;
        for (int j = 0; j < n; j++) begin
            bit g;
            g = hold && (j >= 7);
            account(j == 0, 1'b0);
            if (j < 2)       push(1'b1, 1'b0, 1'b0, 1'b1);
            else if (j == 2) push(1'b1, 1'b0, 1'b1, 1'b0);
            else             push(!g, g, 1'b0, g);
            step((j == 0) ? 1'b1 : hold, 1'b0, j == 0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL wake hold=%0d edge=w+%0d got=%h want=%h", hold, j, observe(), e);
            end
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 8; k++) begin
            push(1'b1, 1'b0, 1'b0, 1'b0);
            step(k < 3, k == 2, 1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL abort_busy edge=%0d got=%h want=%h", k, observe(), e);
            end
        end
        for (int k = 0; k < 8; k++) begin
            push(1'b1, 1'b0, 1'b0, 1'b0);
            step(k <= 4, 1'b0, k == 4, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL abort_wake_cnt0 edge=%0d got=%h want=%h", k, observe(), e);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 11; k++) begin
            push(1'b1, 1'b0, 1'b0, 1'b0);
            step(k < 10, 1'b0, k < 10, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL simultaneous edge=%0d got=%h want=%h", k, observe(), e);
            end
        end
    endtask

    task automatic test_sat_clear();
        account(1'b0, 1'b1);
        push(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front(); n_vec++;
        if (observe() !== e) begin
            n_err++; $display("FAIL clear_run got=%h want=%h", observe(), e);
        end
        test_gate(15);
        for (int k = 0; k < 4; k++) begin
            account(1'b1, k == 0);
            push(1'b0, 1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0, k == 0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL clear_gated k=%0d got=%h want=%h", k, observe(), e);
            end
        end
        test_wake(1'b0);
    endtask

    task automatic test_reset_mid();
        test_gate(6);
        #2; rst = 1'b1; #1;
        g32 = 32'd0; g3 = 3'd0;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); n_vec++;
        if (observe() !== e) begin
            n_err++; $display("FAIL reset_in_gated got=%h want=%h", observe(), e);
        end
        @(posedge clk); #3; rst = 1'b0;
        test_gate(5);
        account(1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = sb.pop_front(); n_vec++;
        if (observe() !== e) begin
            n_err++; $display("FAIL enter_wake got=%h want=%h", observe(), e);
        end
        #2; rst = 1'b1; #1;
        g32 = 32'd0; g3 = 3'd0;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        e = sb.pop_front(); n_vec++;
        if (observe() !== e) begin
            n_err++; $display("FAIL reset_in_wake got=%h want=%h", observe(), e);
        end
        @(posedge clk); #3; rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            e = sb.pop_front(); n_vec++;
            if (observe() !== e) begin
                n_err++; $display("FAIL post_reset_no_ack k=%0d got=%h want=%h", k, observe(), e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_gate(10);
        test_wake(1'b0);
        test_abort();
        test_simultaneous();
        test_gate(6);
        test_wake(1'b1);
        test_wake(1'b0);
        test_sat_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
